// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader:
//                loader state encoding, bytes-per-word constant and the base
//                address alignment check.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Loader states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam int C_WORD_BYTES = 4;
    localparam int C_LANE_W     = $clog2(C_WORD_BYTES);

    // True when a byte address sits on a 32-bit word boundary.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr & 32'h0000_0003) == 32'h0000_0000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Collects a byte stream into 32-bit little-endian words. The
//                first byte lands in bits [7:0]. A word completes on the
//                fourth byte or on a byte flagged last; lanes never filled
//                read as zero. Reusable for any memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [C_LANE_W-1:0] r_lane;
    logic [31:0]         r_word;
    logic [31:0]         w_word_next;

    // Merge the incoming byte into its lane of the partially built word.
    always_comb begin
        w_word_next = r_word;
        w_word_next[{r_lane, 3'b000} +: 8] = i_data;
    end

    assign o_word      = w_word_next;
    assign o_word_done = i_accept &&
                         ((r_lane == C_LANE_W'(C_WORD_BYTES - 1)) || i_last);

    // Advance the lane per accepted byte; restart empty once a word completes
    // so the next word's unfilled lanes stay zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_accept) begin
            if (o_word_done) begin
                r_lane <= '0;
                r_word <= '0;
            end else begin
                r_lane <= r_lane + C_LANE_W'(1);
                r_word <= w_word_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a boot image from a byte stream into instruction
//                memory, one 32-bit word write per four bytes (or fewer on
//                the final byte), and holds the CPU in reset until done.
//                Optional macro LOADER_CHECKSUM_EN enables a running 32-bit
//                sum of written words on the checksum port.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [31:0] word_count,
    output logic [31:0] checksum
);

    localparam logic [31:0] C_MEM_WORDS = 32'(MEM_WORDS);
    localparam logic [31:0] C_BASE_ADDR = {BASE_ADDR[31:2], 2'b00};

    if (!is_word_aligned(BASE_ADDR)) begin : g_base_addr_check
        $error("imem_loader: BASE_ADDR must be 4-aligned");
    end

    state_t      r_state;
    logic        r_last;
    logic        w_accept;
    logic        w_overflow;
    logic        w_pack_accept;
    logic        w_start_ok;
    logic        w_word_done;
    logic [31:0] w_word;

    assign w_accept      = byte_valid && byte_ready;
    // A byte arriving once memory is full is swallowed and flags overflow.
    assign w_overflow    = w_accept && (word_count == C_MEM_WORDS);
    assign w_pack_accept = w_accept && !w_overflow;
    assign w_start_ok    = start && ((r_state == ST_IDLE) ||
                                     (r_state == ST_DONE) ||
                                     (r_state == ST_ERROR));

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_start_ok),
        .i_accept    (w_pack_accept),
        .i_data      (byte_data),
        .i_last      (byte_last),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    // Loader control: sequences LOAD/WRITE per word and drives every
    // handshake and status output from registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= C_BASE_ADDR;
            mem_wdata  <= 32'h0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        byte_ready <= 1'b1;
                        word_count <= 32'h0;
                        load_done  <= 1'b0;
                        load_err   <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_overflow) begin
                        r_state    <= ST_ERROR;
                        byte_ready <= 1'b0;
                        load_err   <= 1'b1;
                    end else if (w_word_done) begin
                        r_state    <= ST_WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= C_BASE_ADDR + (word_count << 2);
                        mem_wdata  <= w_word;
                        r_last     <= byte_last;
                    end
                end
                ST_WRITE: begin
                    mem_we     <= 1'b0;
                    word_count <= word_count + 32'd1;
                    if (r_last) begin
                        r_state   <= ST_DONE;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        r_state    <= ST_LOAD;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Running wrapping sum of every word written; restarts with each load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= 32'h0;
        end else if (w_start_ok) begin
            r_checksum <= 32'h0;
        end else if (r_state == ST_WRITE) begin
            r_checksum <= r_checksum + mem_wdata;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected memory writes
//                are derived from each image (little-endian, zero-padded
//                words, truncated at the memory size) and queued; a monitor
//                compares every write strobe against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int          TB_MEM_WORDS = 4;
    localparam logic [31:0] TB_BASE      = 32'h0000_0040;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [31:0] word_count;
    logic [31:0] checksum;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    imem_loader #(
        .MEM_WORDS (TB_MEM_WORDS),
        .BASE_ADDR (TB_BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b0 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk1("spurious_write", mem_we, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk32("write_addr", mem_addr, e.addr);
                chk32("write_data", mem_wdata, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check_reset_values(input string tag);
        chk1 ({tag, "_byte_ready"}, byte_ready, 1'b0);
        chk1 ({tag, "_mem_we"},     mem_we,     1'b0);
        chk32({tag, "_mem_addr"},   mem_addr,   TB_BASE);
        chk32({tag, "_mem_wdata"},  mem_wdata,  32'h0);
        chk1 ({tag, "_cpu_hold"},   cpu_hold,   1'b1);
        chk1 ({tag, "_load_done"},  load_done,  1'b0);
        chk1 ({tag, "_load_err"},   load_err,   1'b0);
        chk32({tag, "_word_count"}, word_count, 32'h0);
        chk32({tag, "_checksum"},   checksum,   32'h0);
    endtask

    // Called aligned just after a rising edge; returns aligned the same way.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap,
                             input bit noise, output bit ok);
        for (int g = 0; g < gap; g++) begin
            start = noise && (g == 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = last;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        if (!ok) chk1("byte_ready_timeout", byte_ready, 1'b1);
    endtask

    task automatic run_image(input bq_t img, input int gap_lo, input int gap_hi,
                             input bit noise, input string tag);
        int          len;
        int          nwords;
        int          nwr;
        int          n_acc;
        bit          exp_err;
        bit          ok;
        logic [31:0] sum;
        logic [31:0] exp_ck;
        len     = img.size();
        nwords  = (len + 3) / 4;
        exp_err = nwords > TB_MEM_WORDS;
        nwr     = exp_err ? TB_MEM_WORDS : nwords;
        n_acc   = exp_err ? TB_MEM_WORDS * 4 + 1 : len;
        sum     = 32'h0;
        for (int w = 0; w < nwr; w++) begin
            logic [31:0] word;
            word = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < len) word = word | (32'(img[4 * w + b]) << (8 * b));
            exp_q.push_back('{addr: TB_BASE + 32'(4 * w), data: word});
            sum = sum + word;
        end
`ifdef LOADER_CHECKSUM_EN
        exp_ck = sum;
`else
        exp_ck = 32'h0;
`endif
        do_start();
        chk1 ({tag, "_start_hold"},  cpu_hold,   1'b1);
        chk1 ({tag, "_start_done"},  load_done,  1'b0);
        chk32({tag, "_start_count"}, word_count, 32'h0);
        for (int i = 0; i < n_acc; i++) begin
            send_byte(img[i], (i == len - 1), int'($urandom_range(gap_hi, gap_lo)), noise, ok);
            if (!ok) return;
            if (i == 3 && len > 4) begin
                @(posedge clk); #1;
                chk32({tag, "_mid_count"}, word_count, 32'd1);
                chk1 ({tag, "_mid_hold"},  cpu_hold,   1'b1);
                chk1 ({tag, "_mid_ready"}, byte_ready, 1'b1);
            end
        end
        @(negedge clk);
        if (!exp_err) begin
            chk1("write_latency", mem_we, 1'b1);
            @(negedge clk);
            chk1 ({tag, "_done"},       load_done,  1'b1);
            chk1 ({tag, "_hold_free"},  cpu_hold,   1'b0);
            chk1 ({tag, "_err_clear"},  load_err,   1'b0);
        end else begin
            chk1 ({tag, "_err"},        load_err,   1'b1);
            chk1 ({tag, "_err_hold"},   cpu_hold,   1'b1);
            chk1 ({tag, "_err_nodone"}, load_done,  1'b0);
            chk1 ({tag, "_err_no_we"},  mem_we,     1'b0);
        end
        chk1 ({tag, "_ready_low"}, byte_ready, 1'b0);
        chk32({tag, "_count"},     word_count, 32'(nwr));
        chk32({tag, "_checksum"},  checksum,   exp_ck);
        repeat (3) @(negedge clk);
        chk32({tag, "_pending"},   32'(exp_q.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        bq_t img;
        bit  ok;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_reset_values("in_reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_values("after_reset");

        img = '{8'h13, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h02, 8'h10, 8'h00};
        run_image(img, 0, 0, 1'b0, "two_words");

        img = '{8'hAA, 8'hBB, 8'hCC};
        run_image(img, 0, 0, 1'b0, "partial");

        img = '{8'h13, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h02, 8'h10, 8'h00};
        run_image(img, 2, 2, 1'b1, "gapped");

        img = {};
        for (int i = 0; i < TB_MEM_WORDS * 4 + 1; i++) img.push_back(8'(i + 1));
        run_image(img, 0, 1, 1'b0, "overflow");

        // Reset after two bytes of a word, then reload from scratch.
        do_start();
        send_byte(8'h11, 1'b0, 0, 1'b0, ok);
        send_byte(8'h22, 1'b0, 0, 1'b0, ok);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_image(img, 0, 0, 1'b0, "sum_1_2");

        for (int r = 0; r < 12; r++) begin
            int n;
            n = int'($urandom_range(20, 1));
            img = {};
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            run_image(img, 0, 3, (($urandom & 1) == 1), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the instruction memory. Accepts a boot image as an 8-bit byte stream over a valid/ready handshake and assembles the bytes little-endian into 32-bit instructions. Writes each completed word into instruction memory through a word-aligned byte-address write port. Holds the CPU in reset until the whole image is loaded.

Parameters:
MEM_WORDS, 1024, instruction memory depth in 32-bit words; writes beyond it are an overflow.
BASE_ADDR, 32'h0, byte address of the first written word; must be 4-aligned.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load, honoured only in IDLE/DONE/ERROR
byte_valid  input  1  byte_data valid this cycle
byte_data  input  8  image byte, little-endian within each word
byte_last  input  1  qualifies the final byte of the image (sampled with byte_valid)
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_addr  output  32  byte address of the write, always 4-aligned, same addressing as the fetch pc
mem_wdata  output  32  instruction word to write
cpu_hold  output  1  keeps the core in reset while high
load_done  output  1  image fully written (level)
load_err  output  1  sticky overflow error (level)
word_count  output  32  words written since start
checksum  output  32  see Optional Feature

Behaviour:
- Reset values: state IDLE; byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, word_count=0, checksum=0. Byte lane index and the assembly register also clear.
- States: IDLE, LOAD, WRITE, DONE, ERROR.
- IDLE, DONE, ERROR:
  - byte_ready=0.
  - start -> LOAD. Clears word_count, byte lane, assembly register, load_done, load_err and checksum, and sets cpu_hold=1.
  - IDLE holds cpu_hold=1.
- LOAD:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready. It goes into lane k = byte lane index: first byte -> bits[7:0], fourth -> [31:24].
  - The word completes when lane 3 is accepted, or when byte_last is accepted at any lane. Unfilled upper lanes are zero.
  - Word completion -> WRITE. start is ignored while in LOAD.
- WRITE:
  - Exactly one cycle: mem_we=1, mem_addr=BASE_ADDR + 4*word_count, mem_wdata=assembled word, byte_ready=0.
  - Next cycle: word_count+1, lane and assembly register clear.
  - Then -> DONE if the completing byte had byte_last, else -> LOAD.
  - Latency: mem_we asserts the cycle after the completing byte is accepted.
- DONE: cpu_hold=0, load_done=1.
- Overflow: word_count==MEM_WORDS while in LOAD and any byte accepted -> ERROR. No write occurs, load_err=1, cpu_hold stays 1.
- Address arithmetic is 32-bit and wraps modulo 2^32; with legal parameters it never wraps.
- byte_last with an empty stream (start, then no bytes) never occurs; the loader waits in LOAD indefinitely.
- Reset mid-load returns everything to reset values. Memory contents already written are left as-is.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: checksum accumulates the 32-bit wrapping sum of every mem_wdata written. It updates in the WRITE cycle's next edge, clears on start, and is stable in DONE.
- Undefined: the checksum port is constant 0 and no adder is synthesised.

Decomposition:
- Shared package: state enum (IDLE/LOAD/WRITE/DONE/ERROR), the WORD_BYTES=4 constant, and the BASE_ADDR alignment check.
- Sub-module byte_packer (lane counter plus 32-bit little-endian assembly register with zero-pad-on-last). It is reusable for a future data memory loader.

Test Plan:
- Reset, then start, then bytes 13,00,10,00 -> one mem_we at addr 0 with wdata 32'h00100013; word_count=1; cpu_hold stays 1.
- Two words, the second with byte_last on byte 8 (bytes B3,02,10,00 last) -> writes at 0x0 and 0x4; load_done=1 and cpu_hold=0 the cycle after the second write.
- Partial word: 3 bytes AA,BB,CC with last on CC -> wdata 32'h00CCBBAA, then DONE.
- Gapped byte_valid (one byte every 3 cycles), plus start pulses during LOAD -> identical writes; start ignored.
- MEM_WORDS=2, feed 9 bytes -> two writes, then ERROR on byte 9; load_err=1, no third mem_we, cpu_hold=1.
- Assert reset after 2 bytes of a word -> all outputs to reset values; a fresh start reloads from BASE_ADDR. With LOADER_CHECKSUM_EN and words 1 and 2 -> checksum=3.
